// File: rtl/video_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_tx
// Description : Raster timing generator with a moving checkered target box.
//               Counters h/v sweep the full frame while run=1; all outputs are
//               registered one cycle behind the counters. The box position is
//               updated only at the frame boundary, either from a pending
//               load request (clamped) or by bouncing motion.
// Ports       : clk, rst_n (async, active low), run, move_en, step_x, step_y,
//               load_pos, pos_x, pos_y -> tx_de, tx_hsync, tx_vsync,
//               pixel_out, frame_start, target_x, target_y
// Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_tx #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         BOX      = 21,
    parameter int         INIT_X   = 100,
    parameter int         INIT_Y   = 100,
    parameter logic [7:0] BG       = 8'h10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        move_en,
    input  logic [3:0]  step_x,
    input  logic [3:0]  step_y,
    input  logic        load_pos,
    input  logic [11:0] pos_x,
    input  logic [10:0] pos_y,
    output logic        tx_de,
    output logic        tx_hsync,
    output logic        tx_vsync,
    output logic [7:0]  pixel_out,
    output logic        frame_start,
    output logic [11:0] target_x,
    output logic [10:0] target_y
);

    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BOX_X    = 12'(BOX);
    localparam logic [10:0] BOX_Y    = 11'(BOX);
    localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - BOX);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - BOX);
    localparam logic signed [13:0] X_MAX_S = 14'(H_ACTIVE - BOX);
    localparam logic signed [13:0] Y_MAX_S = 14'(V_ACTIVE - BOX);

    logic [11:0] h;
    logic [10:0] v;
    logic        dir_x;          // 1 = moving toward smaller coordinates
    logic        dir_y;
    logic        pend_valid;
    logic [11:0] pend_x;
    logic [10:0] pend_y;

    // ------------------------------------------------------------------
    // Combinational decode of the current counter position
    // ------------------------------------------------------------------
    logic        de_now;
    logic        in_box;
    logic [11:0] off_x;
    logic [10:0] off_y;
    logic [7:0]  pix_now;
    logic        boundary;

    assign de_now   = (h < H_ACT) && (v < V_ACT);
    assign off_x    = h - target_x;
    assign off_y    = v - target_y;
    assign in_box   = (h >= target_x) && (h < target_x + BOX_X) &&
                      (v >= target_y) && (v < target_y + BOX_Y);
    assign boundary = run && (h == H_LAST) && (v == V_LAST);

    always_comb begin
        pix_now = 8'h00;
        if (de_now) begin
            if (in_box) begin
                // Bit 2 of the XOR of the offsets gives a 4x4 checkerboard.
                pix_now = (off_x[2] ^ off_y[2]) ? 8'h40 : 8'hFF;
            end else begin
                pix_now = BG;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next target position: pending load (clamped) or bouncing motion.
    // Motion uses 14-bit signed math so a step below zero is seen as
    // negative rather than wrapping to a large unsigned value.
    // ------------------------------------------------------------------
    logic signed [13:0] nx;
    logic signed [13:0] ny;
    logic [11:0]        load_x;
    logic [10:0]        load_y;

    always_comb begin
        nx = dir_x ? ($signed({2'b00, target_x}) - $signed({10'd0, step_x}))
                   : ($signed({2'b00, target_x}) + $signed({10'd0, step_x}));
        ny = dir_y ? ($signed({3'b000, target_y}) - $signed({10'd0, step_y}))
                   : ($signed({3'b000, target_y}) + $signed({10'd0, step_y}));
    end

    assign load_x = (pend_x > X_MAX) ? X_MAX : pend_x;
    assign load_y = (pend_y > Y_MAX) ? Y_MAX : pend_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= 12'd0;
            v           <= 11'd0;
            tx_de       <= 1'b0;
            tx_hsync    <= 1'b0;
            tx_vsync    <= 1'b0;
            frame_start <= 1'b0;
            pixel_out   <= 8'h00;
            target_x    <= 12'(INIT_X);
            target_y    <= 11'(INIT_Y);
            dir_x       <= 1'b0;
            dir_y       <= 1'b0;
            pend_valid  <= 1'b0;
            pend_x      <= 12'd0;
            pend_y      <= 11'd0;
        end else begin
            // A new request always wins; otherwise the boundary consumes it.
            if (load_pos) begin
                pend_valid <= 1'b1;
                pend_x     <= pos_x;
                pend_y     <= pos_y;
            end else if (boundary && pend_valid) begin
                pend_valid <= 1'b0;
            end

            if (run) begin
                tx_de       <= de_now;
                tx_hsync    <= (h >= HS_START) && (h < HS_END);
                tx_vsync    <= (v >= VS_START) && (v < VS_END);
                frame_start <= (h == 12'd0) && (v == 11'd0);
                pixel_out   <= pix_now;

                if (h == H_LAST) begin
                    h <= 12'd0;
                    v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
                end else begin
                    h <= h + 12'd1;
                end

                if (boundary) begin
                    if (pend_valid) begin
                        target_x <= load_x;
                        target_y <= load_y;
                    end else if (move_en) begin
                        if (nx[13]) begin
                            target_x <= 12'd0;
                            dir_x    <= ~dir_x;
                        end else if (nx > X_MAX_S) begin
                            target_x <= X_MAX;
                            dir_x    <= ~dir_x;
                        end else begin
                            target_x <= nx[11:0];
                        end
                        if (ny[13]) begin
                            target_y <= 11'd0;
                            dir_y    <= ~dir_y;
                        end else if (ny > Y_MAX_S) begin
                            target_y <= Y_MAX;
                            dir_y    <= ~dir_y;
                        end else begin
                            target_y <= ny[10:0];
                        end
                    end
                end
            end else begin
                h           <= 12'd0;
                v           <= 11'd0;
                tx_de       <= 1'b0;
                tx_hsync    <= 1'b0;
                tx_vsync    <= 1'b0;
                frame_start <= 1'b0;
                pixel_out   <= 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_pattern_tx
// Description : Randomized scoreboard bench for video_pattern_tx using a
//               shrunken raster so many frames fit in a short run. A
//               reference model predicts every output cycle; a monitor pops
//               and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_tx;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 56
    localparam int VT = VA + VF + VS + VB;   // 37
    localparam int BOXP = 9, IX = 10, IY = 8;
    localparam logic [7:0] BGP = 8'h10;
    localparam int NCYC = 45000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        move_en = 1'b0;
    logic [3:0]  step_x = 4'd0;
    logic [3:0]  step_y = 4'd0;
    logic        load_pos = 1'b0;
    logic [11:0] pos_x = 12'd0;
    logic [10:0] pos_y = 11'd0;
    logic        tx_de, tx_hsync, tx_vsync, frame_start;
    logic [7:0]  pixel_out;
    logic [11:0] target_x;
    logic [10:0] target_y;

    video_pattern_tx #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BOX(BOXP), .INIT_X(IX), .INIT_Y(IY), .BG(BGP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .move_en(move_en),
        .step_x(step_x), .step_y(step_y), .load_pos(load_pos),
        .pos_x(pos_x), .pos_y(pos_y), .tx_de(tx_de), .tx_hsync(tx_hsync),
        .tx_vsync(tx_vsync), .pixel_out(pixel_out), .frame_start(frame_start),
        .target_x(target_x), .target_y(target_y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [7:0]  pix;
        logic [11:0] tx;
        logic [10:0] ty;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_fs  = 0;
    int   n_bounce = 0;

    // Expected luma of raster point (h,v) for a box at (tx,ty).
    function automatic logic [7:0] ref_pix(int h, int v, int tx, int ty);
        if (!(h < HA && v < VA)) return 8'h00;
        if (h >= tx && h < tx + BOXP && v >= ty && v < ty + BOXP)
            return ((((h - tx) ^ (v - ty)) & 4) == 0) ? 8'hFF : 8'h40;
        return BGP;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: positions as plain integers, direction as +1/-1.
    // ------------------------------------------------------------------
    initial begin : model
        int m_h, m_v, m_tx, m_ty, m_dx, m_dy, m_pv, m_px, m_py, nx, ny;
        exp_t e;
        m_h = 0; m_v = 0; m_tx = IX; m_ty = IY; m_dx = 1; m_dy = 1;
        m_pv = 0; m_px = 0; m_py = 0;
        forever begin
            @(posedge clk);
            e = '0;
            if (!rst_n) begin
                m_h = 0; m_v = 0; m_tx = IX; m_ty = IY; m_dx = 1; m_dy = 1;
                m_pv = 0;
            end else begin
                if (run) begin
                    e.de  = (m_h < HA) && (m_v < VA);
                    e.hs  = (m_h >= HA + HF) && (m_h < HA + HF + HS);
                    e.vs  = (m_v >= VA + VF) && (m_v < VA + VF + VS);
                    e.fs  = (m_h == 0) && (m_v == 0);
                    e.pix = ref_pix(m_h, m_v, m_tx, m_ty);
                    if (m_h == HT - 1 && m_v == VT - 1) begin
                        if (m_pv != 0) begin
                            m_tx = (m_px > HA - BOXP) ? HA - BOXP : m_px;
                            m_ty = (m_py > VA - BOXP) ? VA - BOXP : m_py;
                            m_pv = 0;
                        end else if (move_en) begin
                            nx = m_tx + m_dx * int'(step_x);
                            ny = m_ty + m_dy * int'(step_y);
                            if (nx < 0)              begin nx = 0;         m_dx = 1;  n_bounce++; end
                            else if (nx > HA - BOXP) begin nx = HA - BOXP; m_dx = -1; n_bounce++; end
                            if (ny < 0)              begin ny = 0;         m_dy = 1;  end
                            else if (ny > VA - BOXP) begin ny = VA - BOXP; m_dy = -1; end
                            m_tx = nx; m_ty = ny;
                        end
                    end
                    m_h = m_h + 1;
                    if (m_h == HT) begin
                        m_h = 0;
                        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                    end
                end else begin
                    m_h = 0; m_v = 0;
                end
                if (load_pos) begin
                    m_pv = 1; m_px = int'(pos_x); m_py = int'(pos_y);
                end
            end
            e.tx = 12'(m_tx);
            e.ty = 11'(m_ty);
            sbq.push_back(e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
            if (n_err >= 30) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one expected entry per clock; compared mid-cycle.
    // While reset is held the outputs must show the reset state.
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                if (!rst_n) begin
                    check("reset_timing", {28'd0, tx_de, tx_hsync, tx_vsync, frame_start}, 32'd0);
                    check("reset_pixel", {24'd0, pixel_out}, 32'd0);
                    check("reset_target", {9'd0, target_x, target_y}, {9'd0, 12'(IX), 11'(IY)});
                end else begin
                    check("timing", {28'd0, tx_de, tx_hsync, tx_vsync, frame_start},
                          {28'd0, e.de, e.hs, e.vs, e.fs});
                    check("pixel", {24'd0, pixel_out}, {24'd0, e.pix});
                    check("target", {9'd0, target_x, target_y}, {9'd0, e.tx, e.ty});
                    if (frame_start) n_fs++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int idle_left;
        int rst_at;
        idle_left = 0;
        rst_at = 30000 + int'($urandom_range(0, 1500));
        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        run     = 1'b1;
        move_en = 1'b1;
        step_x  = 4'd5;
        step_y  = 4'd3;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #2;
            load_pos = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 3) == 0) begin
                pos_x = 12'($urandom_range(0, 4095));
                pos_y = 11'($urandom_range(0, 2047));
            end else begin
                pos_x = 12'($urandom_range(0, 40));
                pos_y = 11'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 999) == 0) begin
                move_en = ($urandom_range(0, 3) != 0);
                step_x  = 4'($urandom_range(0, 15));
                step_y  = 4'($urandom_range(0, 15));
            end
            if (idle_left > 0) begin
                idle_left--;
                run = (idle_left == 0);
            end else if ($urandom_range(0, 3999) == 0) begin
                idle_left = int'($urandom_range(1, 50));
                run = 1'b0;
            end
            if (c == rst_at)     rst_n = 1'b0;
            if (c == rst_at + 3) rst_n = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("frames_seen_nonzero", {31'd0, (n_fs > 5)}, 32'd1);
        check("bounces_seen_nonzero", {31'd0, (n_bounce > 0)}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_pattern_tx.md
VIDEO_PATTERN_TX -- requirements
Module: video_pattern_tx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
 - H_ACTIVE, 640, active pixels per line
 - H_FP, 16, horizontal front porch
 - H_SYNC, 96, hsync width
 - H_BP, 48, horizontal back porch; H_TOTAL = sum = 800
 - V_ACTIVE, 480, active lines
 - V_FP, 10, vertical front porch
 - V_SYNC, 2, vsync width
 - V_BP, 33, vertical back porch; V_TOTAL = 525
 - BOX, 21, target square side in pixels
 - INIT_X, 100, reset target left edge
 - INIT_Y, 100, reset target top edge
 - BG, 8'h10, background level
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
 - clk  in  1  pixel clock; the only clock
 - rst_n  in  1  asynchronous, active-low reset
 - run  in  1  1 = generate timing; 0 = idle
 - move_en  in  1  enables per-frame target motion
 - step_x  in  4  unsigned horizontal step magnitude per frame
 - step_y  in  4  unsigned vertical step magnitude per frame
 - load_pos  in  1  one-cycle request to relocate target
 - pos_x  in  12  requested left edge, sampled with load_pos
 - pos_y  in  11  requested top edge, sampled with load_pos
 - tx_de  out  1  data enable
 - tx_hsync  out  1  hsync, active high
 - tx_vsync  out  1  vsync, active high
 - pixel_out  out  8  luma
 - frame_start  out  1  one-cycle pulse with first pixel of frame
 - target_x  out  12  left edge of box in current frame
 - target_y  out  11  top edge of box in current frame

Function
REQ-003 Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) SHALL advance once per clk while run=1; h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
REQ-004 All outputs SHALL be registered and reflect counter state (h,v) one cycle after the counters hold (h,v).
REQ-005 tx_de SHALL be 1 if and only if h<H_ACTIVE and v<V_ACTIVE.
REQ-006 tx_hsync SHALL be 1 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], on every line.
REQ-007 tx_vsync SHALL be 1 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for all h.
REQ-008 frame_start SHALL be 1 exactly when the outputs correspond to (h,v)=(0,0).
REQ-009 pixel_out SHALL be 0 when tx_de=0; inside the box (target_x<=h<target_x+BOX, target_y<=v<target_y+BOX) it SHALL be 8'hFF when bit 2 of ((h-target_x) XOR (v-target_y)) is 0 and 8'h40 otherwise; elsewhere BG.
REQ-010 target_x/target_y SHALL change only at the frame boundary cycle (h=H_TOTAL-1, v=V_TOTAL-1, run=1) and SHALL never change mid-frame.
REQ-011 A load_pos pulse SHALL latch pos_x/pos_y into a pending register; at the next frame boundary the pending position SHALL be applied, clamped to [0, H_ACTIVE-BOX] and [0, V_ACTIVE-BOX]; a later pulse before the boundary overwrites the earlier one.
REQ-012 Pending load SHALL take priority over motion at the same boundary and SHALL not change direction bits.
REQ-013 With move_en=1 and no pending load, target_x SHALL move by step_x in direction dir_x (reset +); if the result leaves [0, H_ACTIVE-BOX] it SHALL be clamped to the violated limit and dir_x inverted; y likewise with step_y, dir_y, V_ACTIVE.
REQ-014 Position arithmetic SHALL use at least 13-bit signed intermediates so underflow below 0 is detected, not wrapped.
REQ-015 When run=0, counters SHALL reset to (0,0) and be held; the next output cycle SHALL drive tx_de, tx_hsync, tx_vsync, frame_start, pixel_out to 0; target and pending load SHALL be retained; run 0->1 SHALL begin at (0,0).

Reset
REQ-016 On rst_n=0, asynchronously: h=v=0, tx_de=tx_hsync=tx_vsync=frame_start=0, pixel_out=0, target_x=INIT_X, target_y=INIT_Y, dir_x=dir_y=+, no pending load.
REQ-017 Reset asserted mid-frame SHALL abort the frame; after release with run=1 the first output frame_start SHALL appear one cycle after the first counter cycle.

Verification
REQ-018 Defaults, run=1: 800 cycles/line, 640 de cycles/line, hsync high for 96 cycles starting at h=656, vsync high on lines 490-491, frame_start every 420000 cycles.
REQ-019 move_en=1, step_x=5, step_y=0: target_x goes 100,105,110... per frame; at 615 next frame gives 619 (clamped) with dir_x negative, then 614.
REQ-020 load_pos with pos_x=4000, pos_y=7 mid-frame: target unchanged until frame boundary, then target_x=619, target_y=7; motion resumes next frame.
REQ-021 Box pixels with target (100,100): (100,100)=FF, (104,100)=40, (120,120)=FF, (121,100)=BG, (700,10) during blanking=0.
REQ-022 run dropped mid-line then re-raised: outputs 0 while idle, restart at (0,0) with frame_start; rst_n pulsed mid-frame: target returns to (100,100).
